fifo_reader: RTL



---
 rtl/shared_pkg.sv | 5 +
 rtl/reader_skid_buf.sv | 33 +++
 rtl/fifo_reader.sv | 79 +++++++
 3 files changed

// File: rtl/shared_pkg.sv
// shared_pkg: common types and constants for the FIFO read side
package shared_pkg;
    localparam int FIFO_WIDTH = 16;
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} reader_state_e;
endpackage

// File: rtl/reader_skid_buf.sv
// reader_skid_buf: 2-entry in-order buffer between the FIFO read port and the output stream
module reader_skid_buf
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] d0, d1;
    assign dout = d0;
    // d0 is always the oldest word; d1 only holds the second word when two are queued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            d0    <= '0;
            d1    <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop)
                d0 <= (push && count == 2'd1) ? din : d1;
            else if (push && count == 2'd0)
                d0 <= din;
            if (push && count == (pop ? 2'd2 : 2'd1))
                d1 <= din;
        end
    end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: credit-based FIFO consumer presenting words on a valid/ready stream with statistics
module fifo_reader
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_read,
    output logic [CNT_WIDTH-1:0]  underflow_cnt,
    output logic                  err
);
    reader_state_e state;
    logic          inflight;
    logic          pop;
    logic [1:0]    buf_count;
    logic [2:0]    credit;

    assign m_valid    = buf_count != 2'd0;
    assign pop        = m_valid && m_ready;
    assign credit     = {1'b0, buf_count} + {2'b0, inflight} - {2'b0, pop};
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (credit < 3'd2);

    reader_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (fifo_data_out),
        .count (buf_count),
        .dout  (m_data)
    );

    // Run/stop control; en always wins, a stop only completes once nothing is buffered or in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else if (en) begin
            state <= RUN;
            busy  <= 1'b1;
        end else if (state == RUN) begin
            state <= STOPPING;
            busy  <= 1'b1;
        end else if (state == STOPPING && !inflight && buf_count == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
        end
    end

    // A read issued this cycle returns data on the FIFO port next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight <= 1'b0;
        else     inflight <= fifo_rd_en;
    end

    // Saturating delivery/underflow statistics and sticky underflow error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_read    <= '0;
            underflow_cnt <= '0;
            err           <= 1'b0;
        end else begin
            words_read    <= words_read + CNT_WIDTH'(pop && !(&words_read));
            underflow_cnt <= underflow_cnt + CNT_WIDTH'(fifo_underflow && !(&underflow_cnt));
            err           <= err | fifo_underflow;
        end
    end
endmodule
